// File: rtl/i2c_slave_if.sv
// Register-bank strobe and status bundle between the I2C target and its register bank.
`timescale 1ns/1ps
interface i2c_slave_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       done;
    logic       nack_rx;
    logic [3:0] state;

    // Handshake: reg_wr/reg_rd are single-cycle strobes qualified by reg_addr;
    // the bank must present reg_rdata on the cycle after reg_rd is high.
    modport slave (
        output reg_addr, reg_wdata, reg_wr, reg_rd, busy, done, nack_rx, state,
        input  reg_rdata
    );

    modport master (
        input  reg_addr, reg_wdata, reg_wr, reg_rd, busy, done, nack_rx, state,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with an 8-bit auto-incrementing register pointer, driven from an
// oversampled SCL/SDA pair; exposes strobes to a register bank.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    i2c_slave_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       got8_q, got8_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       nack_q, nack_d;
    logic       reg_wr_q, reg_wr_d;
    logic       reg_rd_q, reg_rd_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       ld_tx_q, ld_tx_d;
    logic       inc_q, inc_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.nack_rx   = nack_q;
    assign bus.state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizers reset to the idle-bus level so reset never fakes a START
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd7;
            got8_q      <= 1'b0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            ld_tx_q     <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[0], scl};
            sda_sync_q  <= {sda_sync_q[0], sda};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            got8_q      <= got8_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            ld_tx_q     <= ld_tx_d;
            inc_q       <= inc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        got8_d      = got8_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        done_d      = 1'b0;
        nack_d      = 1'b0;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        inc_d       = 1'b0;
        ld_tx_d     = reg_rd_q;

        // Read data arrives one cycle after the strobe; pointer bump trails a write by one cycle
        if (ld_tx_q) tx_d = bus.reg_rdata;
        if (inc_q)   reg_addr_d = reg_addr_q + 8'd1;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            done_d   = busy_q;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            got8_d    = 1'b0;
        end else begin
            if ((state_q == ADDR || state_q == REG || state_q == WDATA) && scl_rise) begin
                shift_d = {shift_q[6:0], sda_s};
                if (bit_cnt_q == 3'd0) got8_d = 1'b1;
                else                   bit_cnt_d = bit_cnt_q - 3'd1;
            end
            case (state_q)
                ADDR: begin
                    if (scl_fall && got8_q) begin
                        got8_d    = 1'b0;
                        bit_cnt_d = 3'd7;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            reg_rd_d = shift_q[0];
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd7;
                        got8_d    = 1'b0;
                        if (rw_q) begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = REG;
                        end
                    end
                end
                REG: begin
                    if (scl_fall && got8_q) begin
                        got8_d     = 1'b0;
                        bit_cnt_d  = 3'd7;
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b1;
                        state_d    = REG_ACK;
                    end
                end
                WDATA: begin
                    if (scl_fall && got8_q) begin
                        got8_d      = 1'b0;
                        bit_cnt_d   = 3'd7;
                        sda_oe_d    = 1'b1;
                        reg_wdata_d = shift_q;
                        reg_wr_d    = 1'b1;
                        inc_d       = 1'b1;
                        state_d     = WDATA_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd7;
                        got8_d    = 1'b0;
                        state_d   = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd0) got8_d = 1'b1;
                        else                   bit_cnt_d = bit_cnt_q - 3'd1;
                    end else if (scl_fall) begin
                        if (got8_q) begin
                            got8_d     = 1'b0;
                            sda_oe_d   = 1'b0;
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    // got8 doubles as "master acknowledged" between the ACK rise and fall
                    if (scl_rise) begin
                        if (!sda_s) begin
                            got8_d   = 1'b1;
                            reg_rd_d = 1'b1;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && got8_q) begin
                        got8_d    = 1'b0;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = ~tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        state_d   = RDATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, registered register bank,
// and queues of expected bank strobes checked as they occur.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam int Q = 100;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic m_sda_low;
    wire  sda;
    wire  sda_line;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int nack_cnt = 0;
    int dut_low_cnt = 0;
    int busy_cnt = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  exp_data_q[$];

    i2c_slave_if bus ();

    i2c_slave dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign sda_line = (sda === 1'b0) ? 1'b0 : 1'b1;

    always @(posedge clk) begin
        if (bus.reg_rd) bus.reg_rdata <= bus.reg_addr ^ 8'hFF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every write/read strobe must match the head of its expected queue
    always @(negedge clk) begin
        logic [16:0] exp_w;
        logic [8:0]  exp_r;
        if (bus.done)    done_cnt++;
        if (bus.nack_rx) nack_cnt++;
        if (bus.busy)    busy_cnt++;
        if (sda_line == 1'b0 && !m_sda_low) dut_low_cnt++;
        if (bus.reg_wr) begin
            exp_w = (exp_wr_q.size() != 0) ? {1'b0, exp_wr_q.pop_front()} : 17'h1_0000;
            check("reg_wr", {15'd0, 1'b0, bus.reg_addr, bus.reg_wdata}, {15'd0, exp_w});
        end
        if (bus.reg_rd) begin
            exp_r = (exp_rd_q.size() != 0) ? {1'b0, exp_rd_q.pop_front()} : 9'h100;
            check("reg_rd", {23'd0, 1'b0, bus.reg_addr}, {23'd0, exp_r});
        end
    end

    task automatic m_start();
        if (scl == 1'b0) begin
            m_sda_low = 1'b0; #Q;
            scl = 1'b1;       #Q;
        end
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #Q;
    endtask

    task automatic m_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda_low = ~b[i]; #Q;
            scl = 1'b1;        #(2*Q);
            scl = 1'b0;        #Q;
        end
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        m_bits(b, 8);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        ack = sda_line;   #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic m_read_byte(input logic ack_bit, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = 1'b0; #Q;
            scl = 1'b1;       #Q;
            b[i] = sda_line;  #Q;
            scl = 1'b0;       #Q;
        end
        m_sda_low = ~ack_bit; #Q;
        scl = 1'b1;           #(2*Q);
        scl = 1'b0;           #Q;
        m_sda_low = 1'b0;
    endtask

    task automatic send_expect_ack(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        m_write_byte(b, a);
        check(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  {24'd0, bus.reg_addr},  32'h0);
        check({tag, "_wdata"}, {24'd0, bus.reg_wdata}, 32'h0);
        check({tag, "_strb"},  {28'd0, bus.reg_wr, bus.reg_rd, bus.done, bus.nack_rx}, 32'h0);
        check({tag, "_busy"},  {31'd0, bus.busy},      32'h0);
        check({tag, "_state"}, {28'd0, bus.state},     32'h0);
        check({tag, "_sda"},   {31'd0, sda_line},      32'h1);
    endtask

    initial begin
        logic [7:0] rb;
        int done_before;

        rst = 1'b1;
        scl = 1'b1;
        m_sda_low = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Write burst
        exp_wr_q.push_back(16'h1011);
        exp_wr_q.push_back(16'h1122);
        exp_wr_q.push_back(16'h1233);
        m_start();
        send_expect_ack("wb_addr_ack", 8'hA0, 1'b0);
        send_expect_ack("wb_reg_ack",  8'h10, 1'b0);
        send_expect_ack("wb_d0_ack",   8'h11, 1'b0);
        send_expect_ack("wb_d1_ack",   8'h22, 1'b0);
        send_expect_ack("wb_d2_ack",   8'h33, 1'b0);
        check("wb_busy", {31'd0, bus.busy}, 32'h1);
        m_stop();
        repeat (10) @(negedge clk);
        check("wb_reg_addr", {24'd0, bus.reg_addr}, 32'h13);
        check("wb_done", done_cnt, 32'd1);
        check("wb_wr_left", exp_wr_q.size(), 32'd0);
        check("wb_busy_clr", {31'd0, bus.busy}, 32'h0);

        // Combined read with repeated START
        exp_rd_q.push_back(8'h20);
        exp_rd_q.push_back(8'h21);
        exp_rd_q.push_back(8'h22);
        exp_data_q.push_back(8'hDF);
        exp_data_q.push_back(8'hDE);
        exp_data_q.push_back(8'hDD);
        m_start();
        send_expect_ack("cr_waddr_ack", 8'hA0, 1'b0);
        send_expect_ack("cr_reg_ack",   8'h20, 1'b0);
        m_start();
        send_expect_ack("cr_raddr_ack", 8'hA1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            m_read_byte((i == 2) ? 1'b1 : 1'b0, rb);
            check("cr_rdata", {24'd0, rb}, {24'd0, exp_data_q.pop_front()});
        end
        m_stop();
        repeat (10) @(negedge clk);
        check("cr_nack", nack_cnt, 32'd1);
        check("cr_done", done_cnt, 32'd2);
        check("cr_rd_left", exp_rd_q.size(), 32'd0);
        check("cr_reg_addr", {24'd0, bus.reg_addr}, 32'h23);

        // Address mismatch: bus must stay untouched
        dut_low_cnt = 0;
        busy_cnt = 0;
        m_start();
        send_expect_ack("mm_addr_nak", 8'hB0, 1'b1);
        send_expect_ack("mm_data_nak", 8'h55, 1'b1);
        m_stop();
        repeat (10) @(negedge clk);
        check("mm_sda_low", dut_low_cnt, 32'd0);
        check("mm_busy", busy_cnt, 32'd0);
        check("mm_done", done_cnt, 32'd2);

        // Pointer wrap through 0xFF
        exp_wr_q.push_back(16'hFE01);
        exp_wr_q.push_back(16'hFF02);
        exp_wr_q.push_back(16'h0003);
        m_start();
        send_expect_ack("pw_addr_ack", 8'hA0, 1'b0);
        send_expect_ack("pw_reg_ack",  8'hFE, 1'b0);
        send_expect_ack("pw_d0_ack",   8'h01, 1'b0);
        send_expect_ack("pw_d1_ack",   8'h02, 1'b0);
        send_expect_ack("pw_d2_ack",   8'h03, 1'b0);
        m_stop();
        repeat (10) @(negedge clk);
        check("pw_reg_addr", {24'd0, bus.reg_addr}, 32'h01);
        check("pw_wr_left", exp_wr_q.size(), 32'd0);
        check("pw_done", done_cnt, 32'd3);

        // STOP during bit 4 of a write data byte
        m_start();
        send_expect_ack("ab_addr_ack", 8'hA0, 1'b0);
        send_expect_ack("ab_reg_ack",  8'h80, 1'b0);
        m_bits(8'hA5, 3);
        m_stop();
        repeat (10) @(negedge clk);
        check("ab_state", {28'd0, bus.state}, 32'h0);
        check("ab_reg_addr", {24'd0, bus.reg_addr}, 32'h80);
        check("ab_done", done_cnt, 32'd4);
        check("ab_busy", {31'd0, bus.busy}, 32'h0);

        // Reset while the target drives a read bit low (0x80 ^ 0xFF = 0x7F, bit 7 = 0)
        exp_rd_q.push_back(8'h80);
        m_start();
        send_expect_ack("rs_addr_ack", 8'hA1, 1'b0);
        check("rs_bit7_low", {31'd0, sda_line}, 32'h0);
        done_before = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rs");
        rst = 1'b0;
        m_stop();
        repeat (10) @(negedge clk);
        check("rs_no_done", done_cnt, done_before);
        check("rs_rd_left", exp_rd_q.size(), 32'd0);
        check_reset_outputs("rs_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
